// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bundle: downstream stall/redirect, instruction-memory handshake and
// the IF/ID output slot. The fetch unit sits on the master side.
interface fetch_pc_unit_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16
);
    logic               stall_i;
    logic               redirect_i;
    logic [ADDR_W-1:0]  redirect_pc_i;
    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic               imem_ack_i;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic               if_valid_o;
    logic [INSTR_W-1:0] if_instr_o;
    logic [ADDR_W-1:0]  if_pc_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, runs the imem req/ack handshake, feeds the
// IF/ID slot through a one-entry skid buffer and flushes on EX redirects.
module fetch_pc_unit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}},
    parameter int unsigned          PC_INC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    fetch_pc_unit_if.master    bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  opc_q, opc_d;
    logic               skid_v_q, skid_v_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

    logic ack_s, consume_s, redir_s;

    // An ack only counts while a request is actually on the bus.
    assign ack_s     = bus.imem_ack_i && req_q;
    assign consume_s = valid_q && !bus.stall_i;
    assign redir_s   = bus.redirect_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ: begin
                if (redir_s) begin
                    state_d = ack_s ? ST_REQ : ST_DRAIN;
                end else if (ack_s && valid_q && !consume_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redir_s || consume_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            // The outstanding ack must still be absorbed; a new redirect only retargets pc.
            ST_DRAIN: begin
                if (ack_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        opc_d        = opc_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (redir_s) begin
            pc_d = bus.redirect_pc_i;
        end else if (state_q == ST_REQ && ack_s) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end else begin
            pc_d = pc_q;
        end

        if (redir_s) begin
            valid_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (state_q == ST_WAIT && consume_s) begin
            valid_d  = 1'b1;
            instr_d  = skid_instr_q;
            opc_d    = skid_pc_q;
            skid_v_d = 1'b0;
        end else if (state_q == ST_REQ && ack_s) begin
            if (!valid_q || consume_s) begin
                valid_d = 1'b1;
                instr_d = bus.imem_rdata_i;
                opc_d   = pc_q;
            end else begin
                skid_v_d     = 1'b1;
                skid_instr_d = bus.imem_rdata_i;
                skid_pc_d    = pc_q;
            end
        end else if (consume_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // DRAIN keeps the old address on the bus until its ack returns.
        req_d  = (state_d == ST_REQ) || (state_d == ST_DRAIN);
        addr_d = (state_d == ST_DRAIN) ? addr_q : pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= {INSTR_W{1'b0}};
            opc_q        <= {ADDR_W{1'b0}};
            skid_v_q     <= 1'b0;
            skid_instr_q <= {INSTR_W{1'b0}};
            skid_pc_q    <= {ADDR_W{1'b0}};
        end else begin
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            opc_q        <= opc_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign bus.imem_req_o  = req_q;
    assign bus.imem_addr_o = addr_q;
    assign bus.if_valid_o  = valid_q;
    assign bus.if_instr_o  = instr_q;
    assign bus.if_pc_o     = opc_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized
// run scored against an in-order program-stream model.
module tb_fetch_pc_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_pc_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();
    fetch_pc_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus_w ();

    fetch_pc_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .PC_INC(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    fetch_pc_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE), .PC_INC(1)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w)
    );

    function automatic logic [15:0] mem(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [15:0] tgt,
                         input logic ak, input logic [15:0] dat);
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = tgt;
        bus.imem_ack_i    = ak;
        bus.imem_rdata_i  = dat;
    endtask

    task automatic drive_w(input logic ak, input logic [15:0] dat);
        bus_w.stall_i       = 1'b0;
        bus_w.redirect_i    = 1'b0;
        bus_w.redirect_pc_i = 16'h0000;
        bus_w.imem_ack_i    = ak;
        bus_w.imem_rdata_i  = dat;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        drive_w(1'b0, 16'h0000);
        cyc();
        cyc();
        n_cmp++;
        if ({bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o, bus.if_instr_o, bus.if_pc_o} !==
            {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_state: got req=%b addr=%h v=%b instr=%h pc=%h, want all zero",
                     bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o, bus.if_instr_o, bus.if_pc_o);
        end
        n_cmp++;
        if ({bus_w.imem_req_o, bus_w.imem_addr_o} !== {1'b0, 16'hFFFE}) begin
            n_err++;
            $display("FAIL reset_addr_w: got req=%b addr=%h, want req=0 addr=fffe",
                     bus_w.imem_req_o, bus_w.imem_addr_o);
        end
        rst = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o} !== {1'b1, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL idle_to_req: got req=%b addr=%h v=%b, want req=1 addr=0000 v=0",
                     bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            e = 16'(i);
            drive(1'b0, 1'b0, 16'h0000, 1'b1, mem(bus.imem_addr_o));
            cyc();
            n_cmp++;
            if ({bus.if_valid_o, bus.if_pc_o, bus.if_instr_o, bus.imem_addr_o} !==
                {1'b1, e, mem(e), e + 16'd1}) begin
                n_err++;
                $display("FAIL stream[%0d]: got v=%b pc=%h instr=%h addr=%h, want v=1 pc=%h instr=%h addr=%h",
                         i, bus.if_valid_o, bus.if_pc_o, bus.if_instr_o, bus.imem_addr_o,
                         e, mem(e), e + 16'd1);
            end
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 16'h0000, 1'b1, mem(bus.imem_addr_o));
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if ({bus.if_valid_o, bus.if_pc_o, bus.imem_req_o} !== {1'b1, 16'h0003, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h req=%b, want v=1 pc=0003 req=0",
                         i, bus.if_valid_o, bus.if_pc_o, bus.imem_req_o);
            end
            drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cyc();
        n_cmp++;
        if ({bus.if_valid_o, bus.if_pc_o, bus.if_instr_o, bus.imem_req_o, bus.imem_addr_o} !==
            {1'b1, 16'h0004, mem(16'h0004), 1'b1, 16'h0005}) begin
            n_err++;
            $display("FAIL stall_release: got v=%b pc=%h instr=%h req=%b addr=%h, want 1/0004/a004/1/0005",
                     bus.if_valid_o, bus.if_pc_o, bus.if_instr_o, bus.imem_req_o, bus.imem_addr_o);
        end
        for (int k = 5; k < 7; k++) begin
            logic [15:0] e;
            e = 16'(k);
            drive(1'b0, 1'b0, 16'h0000, 1'b1, mem(bus.imem_addr_o));
            cyc();
            n_cmp++;
            if ({bus.if_valid_o, bus.if_pc_o, bus.if_instr_o} !== {1'b1, e, mem(e)}) begin
                n_err++;
                $display("FAIL stall_resume[%0d]: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                         k, bus.if_valid_o, bus.if_pc_o, bus.if_instr_o, e, mem(e));
            end
        end
    endtask

    task automatic test_redirect_pending();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cyc();
        n_cmp++;
        if ({bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o} !== {1'b1, 16'h0007, 1'b0}) begin
            n_err++;
            $display("FAIL pending_stable: got req=%b addr=%h v=%b, want req=1 addr=0007 v=0",
                     bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o);
        end
        drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000);
        cyc();
        n_cmp++;
        if ({bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o} !== {1'b1, 16'h0007, 1'b0}) begin
            n_err++;
            $display("FAIL drain_hold: got req=%b addr=%h v=%b, want req=1 addr=0007 v=0",
                     bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD);
        cyc();
        n_cmp++;
        if ({bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o} !== {1'b1, 16'h0040, 1'b0}) begin
            n_err++;
            $display("FAIL stale_discard: got req=%b addr=%h v=%b, want req=1 addr=0040 v=0",
                     bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, mem(bus.imem_addr_o));
        cyc();
        n_cmp++;
        if ({bus.if_valid_o, bus.if_pc_o, bus.if_instr_o} !== {1'b1, 16'h0040, 16'hA040}) begin
            n_err++;
            $display("FAIL redirect_first: got v=%b pc=%h instr=%h, want v=1 pc=0040 instr=a040",
                     bus.if_valid_o, bus.if_pc_o, bus.if_instr_o);
        end
    endtask

    task automatic test_redirect_full_skid();
        drive(1'b1, 1'b0, 16'h0000, 1'b1, mem(bus.imem_addr_o));
        cyc();
        n_cmp++;
        if ({bus.if_valid_o, bus.if_pc_o, bus.imem_req_o} !== {1'b1, 16'h0040, 1'b0}) begin
            n_err++;
            $display("FAIL skid_fill: got v=%b pc=%h req=%b, want v=1 pc=0040 req=0",
                     bus.if_valid_o, bus.if_pc_o, bus.imem_req_o);
        end
        drive(1'b1, 1'b1, 16'h0100, 1'b1, 16'hDEAD);
        cyc();
        n_cmp++;
        if ({bus.if_valid_o, bus.imem_req_o, bus.imem_addr_o} !== {1'b0, 1'b1, 16'h0100}) begin
            n_err++;
            $display("FAIL redir_stall_ack: got v=%b req=%b addr=%h, want v=0 req=1 addr=0100",
                     bus.if_valid_o, bus.imem_req_o, bus.imem_addr_o);
        end
        for (int k = 0; k < 2; k++) begin
            logic [15:0] e;
            e = 16'h0100 + 16'(k);
            drive(1'b0, 1'b0, 16'h0000, 1'b1, mem(bus.imem_addr_o));
            cyc();
            n_cmp++;
            if ({bus.if_valid_o, bus.if_pc_o, bus.if_instr_o} !== {1'b1, e, mem(e)}) begin
                n_err++;
                $display("FAIL skid_flushed[%0d]: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                         k, bus.if_valid_o, bus.if_pc_o, bus.if_instr_o, e, mem(e));
            end
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] e;
            e = 16'hFFFE + 16'(i);
            drive_w(1'b1, mem(bus_w.imem_addr_o));
            cyc();
            n_cmp++;
            if ({bus_w.if_valid_o, bus_w.if_pc_o, bus_w.if_instr_o} !== {1'b1, e, mem(e)}) begin
                n_err++;
                $display("FAIL wrap[%0d]: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                         i, bus_w.if_valid_o, bus_w.if_pc_o, bus_w.if_instr_o, e, mem(e));
            end
        end
        drive_w(1'b0, 16'h0000);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD);
        rst = 1'b1;
        cyc();
        n_cmp++;
        if ({bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o, bus.if_instr_o, bus.if_pc_o} !==
            {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_mid: got req=%b addr=%h v=%b instr=%h pc=%h, want all zero",
                     bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o, bus.if_instr_o, bus.if_pc_o);
        end
        rst = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o} !== {1'b1, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL ack_ignored: got req=%b addr=%h v=%b, want req=1 addr=0000 v=0",
                     bus.imem_req_o, bus.imem_addr_o, bus.if_valid_o);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, mem(bus.imem_addr_o));
        cyc();
        n_cmp++;
        if ({bus.if_valid_o, bus.if_pc_o, bus.if_instr_o} !== {1'b1, 16'h0000, 16'hA000}) begin
            n_err++;
            $display("FAIL restart: got v=%b pc=%h instr=%h, want v=1 pc=0000 instr=a000",
                     bus.if_valid_o, bus.if_pc_o, bus.if_instr_o);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] prev_addr;
        logic        prev_pending;
        int          n_cons;
        exp_pc       = 16'h0000;
        prev_addr    = 16'h0000;
        prev_pending = 1'b0;
        n_cons       = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        st, rd, ak;
            logic [15:0] tgt, dat;
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 3);
            tgt = 16'($urandom);
            if (bus.imem_req_o) begin
                ak  = ($urandom_range(0, 99) < 60);
                dat = mem(bus.imem_addr_o);
            end else begin
                ak  = ($urandom_range(0, 99) < 20);
                dat = 16'($urandom);
            end
            if (prev_pending) begin
                n_cmp++;
                if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, prev_addr}) begin
                    n_err++;
                    $display("FAIL rnd_handshake@%0d: got req=%b addr=%h, want req=1 addr=%h",
                             c, bus.imem_req_o, bus.imem_addr_o, prev_addr);
                end
            end
            if (rd) begin
                exp_pc = tgt;
            end else if (bus.if_valid_o && !st) begin
                n_cmp++;
                if ({bus.if_pc_o, bus.if_instr_o} !== {exp_pc, mem(exp_pc)}) begin
                    n_err++;
                    $display("FAIL rnd_stream@%0d: got pc=%h instr=%h, want pc=%h instr=%h",
                             c, bus.if_pc_o, bus.if_instr_o, exp_pc, mem(exp_pc));
                end
                exp_pc = exp_pc + 16'd1;
                n_cons++;
            end
            prev_pending = bus.imem_req_o && !ak;
            prev_addr    = bus.imem_addr_o;
            drive(st, rd, tgt, ak, dat);
            cyc();
        end
        n_cmp++;
        if (n_cons < 300) begin
            n_err++;
            $display("FAIL rnd_progress: got %0d consumed, want at least 300", n_cons);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_pending();
        test_redirect_full_skid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
